// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: EX/MEM payload layout and control-field encodings.
package rv_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_W      = 5;
  localparam int SIZE_CODEW = 3;
  localparam int RES_W      = 2;

  localparam logic [RES_W-1:0] RES_SRC_ALU = 2'd0;
  localparam logic [RES_W-1:0] RES_SRC_MEM = 2'd1;
  localparam logic [RES_W-1:0] RES_SRC_PC4 = 2'd2;

  // Low two bits give the access width, bit 2 marks an unsigned load
  localparam logic [SIZE_CODEW-1:0] SIZE_BYTE  = 3'd0;
  localparam logic [SIZE_CODEW-1:0] SIZE_HALF  = 3'd1;
  localparam logic [SIZE_CODEW-1:0] SIZE_WORD  = 3'd2;
  localparam logic [SIZE_CODEW-1:0] SIZE_BYTEU = 3'd4;
  localparam logic [SIZE_CODEW-1:0] SIZE_HALFU = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]       aluResult;
    logic [XLEN-1:0]       writeData;
    logic [XLEN-1:0]       pcPlus4;
    logic [REG_W-1:0]      rd;
    logic                  regWrite;
    logic [RES_W-1:0]      resultSrc;
    logic                  memWrite;
    logic [SIZE_CODEW-1:0] sizeSrc;
  } exmem_payload_t;

  function automatic int payloadBits(input int dataW, input int regW,
                                     input int sizeW, input int resW);
    return 3 * dataW + regW + 1 + resW + 1 + sizeW;
  endfunction

endpackage

// File: rtl/exmem_stage_skid_buffer.sv
// Generic two-entry skid buffer: registered ready, main entry drives the output.
module skid_buffer #(
  parameter type payload_t = logic [7:0]
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  logic     valid_i,
  output logic     ready_o,
  input  payload_t data_i,
  output logic     valid_o,
  input  logic     ready_i,
  output payload_t data_o
);

  logic     r_mainValid;
  logic     r_skidValid;
  payload_t r_main;
  payload_t r_skid;
  logic     w_inFire;
  logic     w_outFire;

  assign ready_o   = ~r_skidValid;
  assign valid_o   = r_mainValid;
  assign data_o    = r_main;
  assign w_inFire  = valid_i & ~r_skidValid;
  assign w_outFire = r_mainValid & ready_i;

  // Skid only fills when main is stuck, so ready never depends on ready_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush_i) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (!r_mainValid || w_outFire) begin
      if (r_skidValid) begin
        r_main      <= r_skid;
        r_mainValid <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_inFire) begin
        r_main      <= data_i;
        r_mainValid <= 1'b1;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_inFire) begin
      r_skid      <= data_i;
      r_skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/exmem_stage.sv
// Elastic EX/MEM pipeline register with skid buffer and flush.
// Optional EXMEM_PERF_EN adds saturating stall/bubble counters.
module exmem_stage
  import rv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SIZE_WIDTH     = 3,
  parameter int RES_SRC_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      flush_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultE,
  input  logic [DATA_WIDTH-1:0]     WriteDataE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      RegWriteE,
  input  logic [RES_SRC_WIDTH-1:0]  ResultSrcE,
  input  logic                      MemWriteE,
  input  logic [SIZE_WIDTH-1:0]     SizeSrcE,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic [RES_SRC_WIDTH-1:0]  ResultSrcM,
  output logic [SIZE_WIDTH-1:0]     SizeSrcM,
  output logic                      RegWriteM,
  output logic                      MemWriteM
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [DATA_WIDTH-1:0]     writeData;
    logic [DATA_WIDTH-1:0]     pcPlus4;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      regWrite;
    logic [RES_SRC_WIDTH-1:0]  resultSrc;
    logic                      memWrite;
    logic [SIZE_WIDTH-1:0]     sizeSrc;
  } payload_t;

  localparam int PAYLOAD_BITS = payloadBits(DATA_WIDTH, REG_ADDR_WIDTH, SIZE_WIDTH, RES_SRC_WIDTH);

  payload_t w_in;
  payload_t w_out;
  logic     w_valid;
  logic     w_ready;

  assign w_in.aluResult = ALUResultE;
  assign w_in.writeData = WriteDataE;
  assign w_in.pcPlus4   = PCPlus4E;
  assign w_in.rd        = RdE;
  assign w_in.regWrite  = RegWriteE;
  assign w_in.resultSrc = ResultSrcE;
  assign w_in.memWrite  = MemWriteE;
  assign w_in.sizeSrc   = SizeSrcE;

  skid_buffer #(
    .payload_t(payload_t)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ready_o(w_ready),
    .data_i (w_in),
    .valid_o(w_valid),
    .ready_i(ready_i),
    .data_o (w_out)
  );

  assign ready_o    = w_ready;
  assign valid_o    = w_valid;
  assign ALUResultM = w_out.aluResult;
  assign WriteDataM = w_out.writeData;
  assign PCPlus4M   = w_out.pcPlus4;
  assign RdM        = w_out.rd;
  assign ResultSrcM = w_out.resultSrc;
  assign SizeSrcM   = w_out.sizeSrc;

  // Side-effecting controls are gated so squashed or stale entries never write
  assign RegWriteM  = w_out.regWrite & w_valid;
  assign MemWriteM  = w_out.memWrite & w_valid;

  if (PAYLOAD_BITS != $bits(payload_t)) begin : g_widthMismatch
    $error("exmem_stage payload layout out of sync with rv_pipe_pkg");
  end

`ifdef EXMEM_PERF_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_bubbleCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (w_valid && !ready_i && (r_stallCnt != 32'hFFFF_FFFF))
        r_stallCnt <= r_stallCnt + 32'd1;
      if (!w_valid && ready_i && (r_bubbleCnt != 32'hFFFF_FFFF))
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stallCnt;
  assign bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios then random traffic
// against a queue-based model of a two-deep elastic stage.
module tb_exmem_stage;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        regWrite;
      logic [1:0]  resSrc;
      logic        memWrite;
      logic [2:0]  size;
   } tb_payload_t;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic        flush_i;
   logic [31:0] ALUResultE;
   logic [31:0] WriteDataE;
   logic [31:0] PCPlus4E;
   logic [4:0]  RdE;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic [2:0]  SizeSrcE;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;
   logic [4:0]  RdM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  SizeSrcM;
   logic        RegWriteM;
   logic        MemWriteM;
`ifdef EXMEM_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   int          checks;
   int          errors;

   tb_payload_t modelQ[$];
   tb_payload_t lastP;
   logic [31:0] expStall;
   logic [31:0] expBubble;

   exmem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .ALUResultE (ALUResultE),
      .WriteDataE (WriteDataE),
      .PCPlus4E   (PCPlus4E),
      .RdE        (RdE),
      .RegWriteE  (RegWriteE),
      .ResultSrcE (ResultSrcE),
      .MemWriteE  (MemWriteE),
      .SizeSrcE   (SizeSrcE),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .ResultSrcM (ResultSrcM),
      .SizeSrcM   (SizeSrcM),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM)
`ifdef EXMEM_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any disagreement
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic tb_payload_t mkPayload(input logic [31:0] alu, input logic [31:0] wdata,
                                            input logic [4:0] rd, input logic regWrite,
                                            input logic memWrite, input logic [2:0] size);
      tb_payload_t p;
      p.alu      = alu;
      p.wdata    = wdata;
      p.pc4      = alu + 32'd4;
      p.rd       = rd;
      p.regWrite = regWrite;
      p.resSrc   = 2'd0;
      p.memWrite = memWrite;
      p.size     = size;
      return p;
   endfunction

   function automatic tb_payload_t randPayload();
      tb_payload_t p;
      p.alu      = $urandom;
      p.wdata    = $urandom;
      p.pc4      = $urandom;
      p.rd       = 5'($urandom);
      p.regWrite = 1'($urandom);
      p.resSrc   = 2'($urandom_range(0, 2));
      p.memWrite = 1'($urandom);
      p.size     = 3'($urandom);
      return p;
   endfunction

   function automatic void modelReset();
      modelQ.delete();
      lastP     = '0;
      expStall  = '0;
      expBubble = '0;
   endfunction

   // Drives one cycle of inputs, advances the model across the edge, lands on the next negedge
   task automatic applyStimulus(input logic v, input logic f, input logic r, input tb_payload_t p);
      logic inFire;
      logic outFire;
      valid_i    = v;
      flush_i    = f;
      ready_i    = r;
      ALUResultE = p.alu;
      WriteDataE = p.wdata;
      PCPlus4E   = p.pc4;
      RdE        = p.rd;
      RegWriteE  = p.regWrite;
      ResultSrcE = p.resSrc;
      MemWriteE  = p.memWrite;
      SizeSrcE   = p.size;
      inFire  = v && (modelQ.size() < 2);
      outFire = (modelQ.size() > 0) && r;
      if ((modelQ.size() > 0) && !r && (expStall != 32'hFFFF_FFFF)) expStall++;
      if ((modelQ.size() == 0) && r && (expBubble != 32'hFFFF_FFFF)) expBubble++;
      @(posedge clk);
      if (f) begin
         modelQ.delete();
      end else begin
         if (outFire) void'(modelQ.pop_front());
         if (inFire) modelQ.push_back(p);
      end
      if (modelQ.size() > 0) lastP = modelQ[0];
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag);
      logic expValid;
      expValid = (modelQ.size() > 0);
      chk({tag, "_valid"},    64'(valid_o),    64'(expValid));
      chk({tag, "_ready"},    64'(ready_o),    64'(modelQ.size() < 2));
      chk({tag, "_regWrite"}, 64'(RegWriteM),  64'(expValid & lastP.regWrite));
      chk({tag, "_memWrite"}, 64'(MemWriteM),  64'(expValid & lastP.memWrite));
      chk({tag, "_alu"},      64'(ALUResultM), 64'(lastP.alu));
      chk({tag, "_wdata"},    64'(WriteDataM), 64'(lastP.wdata));
      chk({tag, "_pc4"},      64'(PCPlus4M),   64'(lastP.pc4));
      chk({tag, "_rd"},       64'(RdM),        64'(lastP.rd));
      chk({tag, "_resSrc"},   64'(ResultSrcM), 64'(lastP.resSrc));
      chk({tag, "_size"},     64'(SizeSrcM),   64'(lastP.size));
`ifdef EXMEM_PERF_EN
      chk({tag, "_stallCnt"},  64'(stall_cnt),  64'(expStall));
      chk({tag, "_bubbleCnt"}, 64'(bubble_cnt), 64'(expBubble));
`endif
   endtask

   task automatic doReset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      modelReset();
      rst = 1'b1;
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      tb_payload_t idle;
      checks     = 0;
      errors     = 0;
      idle       = '0;
      valid_i    = 1'b0;
      flush_i    = 1'b0;
      ready_i    = 1'b0;
      ALUResultE = '0;
      WriteDataE = '0;
      PCPlus4E   = '0;
      RdE        = '0;
      RegWriteE  = 1'b0;
      ResultSrcE = '0;
      MemWriteE  = 1'b0;
      SizeSrcE   = '0;
      rst        = 1'b0;
      @(negedge clk);
      doReset();
      checkOutput("reset");
      chk("reset_readyLit", 64'(ready_o), 64'd1);
      chk("reset_aluZero",  64'(ALUResultM), 64'd0);

      // Streaming three back-to-back instructions
      applyStimulus(1'b1, 1'b0, 1'b1, mkPayload(32'h10, 32'h1, 5'd1, 1'b1, 1'b0, 3'd2));
      checkOutput("t1_c1");
      chk("t1_alu10", 64'(ALUResultM), 64'h10);
      applyStimulus(1'b1, 1'b0, 1'b1, mkPayload(32'h20, 32'h2, 5'd2, 1'b1, 1'b0, 3'd2));
      checkOutput("t1_c2");
      chk("t1_alu20", 64'(ALUResultM), 64'h20);
      applyStimulus(1'b1, 1'b0, 1'b1, mkPayload(32'h30, 32'h3, 5'd3, 1'b0, 1'b0, 3'd2));
      checkOutput("t1_c3");
      chk("t1_alu30", 64'(ALUResultM), 64'h30);
      chk("t1_ready", 64'(ready_o), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t1_idle");

      // Back-pressure: fill skid, then drain in order
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'hA, 32'h0, 5'd4, 1'b1, 1'b0, 3'd0));
      checkOutput("t2_mainA");
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'hB, 32'h0, 5'd5, 1'b1, 1'b0, 3'd0));
      checkOutput("t2_skidB");
      chk("t2_readyLow", 64'(ready_o), 64'd0);
      chk("t2_holdA",    64'(ALUResultM), 64'hA);
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'hC, 32'h0, 5'd6, 1'b1, 1'b0, 3'd0));
      checkOutput("t2_blockedC");
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t2_drain1");
      chk("t2_outB", 64'(ALUResultM), 64'hB);
      chk("t2_readyBack", 64'(ready_o), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t2_drain2");

      // Flush with both entries full and an incoming instruction
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'h100, 32'h0, 5'd1, 1'b1, 1'b1, 3'd2));
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'h200, 32'h0, 5'd2, 1'b1, 1'b1, 3'd2));
      checkOutput("t3_full");
      applyStimulus(1'b1, 1'b1, 1'b1, mkPayload(32'h700, 32'h0, 5'd7, 1'b1, 1'b0, 3'd0));
      checkOutput("t3_flushed");
      chk("t3_validLit", 64'(valid_o),   64'd0);
      chk("t3_regWrLit", 64'(RegWriteM), 64'd0);
      chk("t3_memWrLit", 64'(MemWriteM), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t3_after");
      chk("t3_noRd7", 64'(valid_o && (RdM == 5'd7)), 64'd0);

      // Store gating lasts exactly one cycle
      applyStimulus(1'b1, 1'b0, 1'b1, mkPayload(32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 3'd2));
      checkOutput("t4_store");
      chk("t4_memWr1", 64'(MemWriteM), 64'd1);
      chk("t4_wdata",  64'(WriteDataM), 64'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t4_idle");
      chk("t4_memWr0", 64'(MemWriteM), 64'd0);

      // Asynchronous reset between edges while skid is full
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'h55, 32'h66, 5'd9, 1'b1, 1'b1, 3'd1));
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'h77, 32'h88, 5'd10, 1'b1, 1'b1, 3'd1));
      checkOutput("t5_full");
      #2 rst = 1'b0;
      #1;
      chk("t5_valid",  64'(valid_o),    64'd0);
      chk("t5_alu",    64'(ALUResultM), 64'd0);
      chk("t5_wdata",  64'(WriteDataM), 64'd0);
      chk("t5_regWr",  64'(RegWriteM),  64'd0);
      chk("t5_memWr",  64'(MemWriteM),  64'd0);
      @(negedge clk);
      doReset();
      checkOutput("t5_released");

`ifdef EXMEM_PERF_EN
      // Four stall cycles then two bubble cycles from a fresh reset
      applyStimulus(1'b1, 1'b0, 1'b0, mkPayload(32'h99, 32'h0, 5'd1, 1'b0, 1'b0, 3'd0));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, idle);
      applyStimulus(1'b0, 1'b0, 1'b1, idle);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, idle);
      checkOutput("t6_perf");
      chk("t6_stall4",  64'(stall_cnt),  64'd4);
      chk("t6_bubble2", 64'(bubble_cnt), 64'd2);
`endif

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 9) < 7), randPayload());
         checkOutput("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
Elastic Execute-to-Memory pipeline stage with a two-entry skid buffer. It replaces the fixed always-advance EX/MEM register with a valid/ready handshake, so a multi-cycle data memory can back-pressure Execute without combinational ready paths. It also adds a synchronous flush for branch/trap squash. It sits between the ALU/forwarding logic and the data-memory/writeback path.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and PC+4
REG_ADDR_WIDTH, 5, destination register index width
SIZE_WIDTH, 3, load/store size/sign code width
RES_SRC_WIDTH, 2, writeback result-select width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
valid_i  in  1  Execute presents a valid instruction
ready_o  out  1  stage can accept; registered, equals NOT skid_valid
flush_i  in  1  synchronous squash of all held entries
ALUResultE  in  DATA_WIDTH  ALU result
WriteDataE  in  DATA_WIDTH  store data
PCPlus4E  in  DATA_WIDTH  PC+4
RdE  in  REG_ADDR_WIDTH  destination register
RegWriteE  in  1  register write enable
ResultSrcE  in  RES_SRC_WIDTH  writeback select
MemWriteE  in  1  memory write enable
SizeSrcE  in  SIZE_WIDTH  access size code
valid_o  out  1  main entry valid
ready_i  in  1  Memory stage accepts main entry
ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM, SizeSrcM  out  as inputs  main-entry payload
RegWriteM  out  1  main RegWrite AND valid_o
MemWriteM  out  1  main MemWrite AND valid_o

Behaviour:
- State: main entry (payload + main_valid) and skid entry (payload + skid_valid). in_fire = valid_i & ready_o. out_fire = valid_o & ready_i.
- Reset (rst=0, async): main_valid=0 and skid_valid=0. All payload registers are 0. valid_o=0, RegWriteM=0, MemWriteM=0, ready_o=1 once released.
- Latency: 1 cycle, input to valid_o. Throughput: 1 per cycle while ready_i=1.
- Update rules when flush_i=0, evaluated per rising edge:
  - Main empty, or out_fire:
    - if skid_valid, main takes the skid entry and skid_valid clears;
    - else if in_fire, main takes the input;
    - else main_valid clears.
  - Main full, no out_fire, and in_fire: the input is written to skid; skid_valid sets.
  - No other case changes state.
- ready_o depends only on skid_valid. There is no combinational path from ready_i to ready_o.
- At most one entry can be in skid. While skid_valid=1, ready_o=0 and no input is accepted.
- flush_i=1: main_valid and skid_valid clear next edge, with priority over in_fire and out_fire. A same-cycle input is dropped. Payload registers keep their contents; RegWriteM and MemWriteM read 0 because they are valid-gated.
- Payload outputs hold while valid_o=1 and ready_i=0. They are stable and must not glitch.
- Reset mid-operation: both entries are discarded immediately.

Optional Feature:
EXMEM_PERF_EN
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with valid_o & ~ready_i.
  - bubble_cnt increments each cycle with ~valid_o & ready_i.
  - Both counters saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush_i.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - typedef exmem_payload_t, a packed struct of all payload fields sized by the parameters;
  - localparams for the ResultSrc encodings (ALU=0, MEM=1, PC4=2) and the SizeSrc encodings.
- One natural sub-module is skid_buffer. It is generic over a packed payload type or width and implements the main/skid valid-ready logic with flush. exmem_stage instantiates it and applies valid-gating to RegWriteM/MemWriteM.

Test Plan:
1. Reset, streaming: rst=0→1, ready_i=1, three back-to-back inputs with ALUResultE=0x10,0x20,0x30 → valid_o=1 on cycles 1,2,3 with ALUResultM=0x10,0x20,0x30; ready_o stays 1.
2. Back-pressure, skid fill and drain: main holds 0xA, ready_i=0, input 0xB accepted → next cycle ready_o=0, ALUResultM stays 0xA. Raise ready_i → outputs 0xA then 0xB in consecutive cycles; ready_o returns to 1.
3. Flush with both entries full, concurrent valid_i=1 (RdE=7, RegWriteE=1) → next cycle valid_o=0, RegWriteM=0, MemWriteM=0, ready_o=1; the RdE=7 instruction never appears.
4. Store gating: input with MemWriteE=1, WriteDataE=0xDEADBEEF, SizeSrcE=2 → MemWriteM=1 for exactly one cycle with ready_i=1, then 0 on the following idle cycle.
5. Async reset mid-stall: skid full, rst driven 0 between clock edges → valid_o and all outputs go to 0 immediately, with no clock edge needed.
6. EXMEM_PERF_EN: 4 cycles of valid_o=1/ready_i=0, then 2 idle cycles with ready_i=1 → stall_cnt=4, bubble_cnt=2.
